serial_subtractor: RTL



---
 rtl/arith_pkg.sv | 11 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library package.
// Holds the state encoding for the bit-serial arithmetic controllers.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell (combinational).
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in
//   diff - difference bit, a - b - bin
//   bout - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, using one full-subtractor cell and a registered borrow.
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake; a and b sampled on accept only
//   a, b                 - minuend / subtrahend, WIDTH bits
//   out_valid/out_ready  - result handshake; result held until taken
//   diff                 - (a - b) mod 2^WIDTH
//   borrow_out           - unsigned borrow (a < b)
//   overflow             - signed overflow of the subtraction
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .diff (cell_d),
        .bout (cell_bout)
    );

    // Difference bits enter at the MSB so that after WIDTH shifts the
    // first-computed (LSB) bit has arrived at position 0.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = cell_d;
    end

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign diff     = res_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow   <= 1'b0;
                        cnt      <= '0;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // The cell output on the final bit is the result MSB.
                        borrow_out <= cell_bout;
                        overflow   <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
